// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO pointer blocks (write side and read side).
package async_fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int PTR_W = DEFAULT_ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** DEFAULT_ADDR_WIDTH;

    // Width-agnostic: zero-extended Gray input yields zero-extended binary.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        for (int s = 1; s < 32; s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary to reflected-Gray converter shared by both pointer blocks.
module bin2gray #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] bin_i,
    output logic [DATA_WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/sync_ff_chain.sv
// Plain multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module sync_ff_chain
    import async_fifo_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wptr_full.sv
// Write-domain pointer, Gray export and full / almost-full / level generation for the async FIFO.
// ADDR_WIDTH must be at least 2 for the full-compare slicing.
module async_fifo_wptr_full
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int ALMOST_FULL_LVL = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH:0]   rd_gray_ptr_i,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic                  wr_push_o,
    output logic [ADDR_WIDTH:0]   wr_gray_ptr_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [ADDR_WIDTH:0]   wr_level_o,
    output logic                  overflow_o
);

    localparam int AW = ADDR_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rq_sync;
    logic [AW:0] rbin_sync;
    logic [AW:0] level_next;
    logic        push;
    logic        full_next;
    logic        almost_full_next;

    assign push      = wr_en_i & ~full_o;
    assign wr_push_o = push;
    assign waddr_o   = wbin[AW-1:0];
    assign wbin_next = wbin + {{AW{1'b0}}, push};

    bin2gray #(
        .DATA_WIDTH(PW)
    ) u_bin2gray (
        .bin_i (wbin_next),
        .gray_o(wgray_next)
    );

    sync_ff_chain #(
        .WIDTH (PW),
        .STAGES(SYNC_STAGES)
    ) u_rq_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (rd_gray_ptr_i),
        .q_o  (rq_sync)
    );

    // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
    assign full_next        = (wgray_next == {~rq_sync[AW:AW-1], rq_sync[AW-2:0]});
    assign rbin_sync        = PW'(gray2bin(32'(rq_sync)));
    assign level_next       = wbin_next - rbin_sync;
    assign almost_full_next = (32'(level_next) >= ALMOST_FULL_LVL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wbin          <= '0;
            wr_gray_ptr_o <= '0;
            full_o        <= 1'b0;
            almost_full_o <= 1'b0;
            wr_level_o    <= '0;
            overflow_o    <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            wr_gray_ptr_o <= wgray_next;
            full_o        <= full_next;
            almost_full_o <= almost_full_next;
            wr_level_o    <= level_next;
            overflow_o    <= wr_en_i & full_o;
        end
    end

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Self-checking bench for the write-side pointer / full-flag block (depth 8, two sync stages).
module tb_async_fifo_wptr_full;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       wr_en_i = 1'b0;
    logic [3:0] rd_gray_ptr_i = 4'h0;
    logic [2:0] waddr_o;
    logic       wr_push_o;
    logic [3:0] wr_gray_ptr_o;
    logic       full_o;
    logic       almost_full_o;
    logic [3:0] wr_level_o;
    logic       overflow_o;

    async_fifo_wptr_full #(
        .ADDR_WIDTH     (3),
        .SYNC_STAGES    (2),
        .ALMOST_FULL_LVL(6)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_en_i      (wr_en_i),
        .rd_gray_ptr_i(rd_gray_ptr_i),
        .waddr_o      (waddr_o),
        .wr_push_o    (wr_push_o),
        .wr_gray_ptr_o(wr_gray_ptr_o),
        .full_o       (full_o),
        .almost_full_o(almost_full_o),
        .wr_level_o   (wr_level_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: unbounded entry counts, reader count seen through two sync stages.
    int   wcnt = 0;
    int   rcnt = 0;
    int   s1 = 0;
    int   s2 = 0;
    int   e_level = 0;
    logic e_full = 1'b0;
    logic e_af = 1'b0;
    logic e_ovf = 1'b0;
    logic e_push = 1'b0;
    logic obs_push = 1'b0;
    logic pre_full = 1'b0;

    function automatic logic [3:0] gray_of(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    function automatic int popcount4(input logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    // One clock cycle: drive, sample push before the edge, advance the model at the edge.
    task automatic tick(input logic we, input logic rs);
        wr_en_i       = we;
        rst_i         = rs;
        rd_gray_ptr_i = gray_of(rcnt);
        #1;
        obs_push = wr_push_o;
        pre_full = full_o;
        @(posedge clk_i);
        if (rs) begin
            wcnt = 0; rcnt = 0; s1 = 0; s2 = 0; e_level = 0;
            e_full = 0; e_af = 0; e_ovf = 0; e_push = 0;
        end else begin
            e_ovf   = we & e_full;
            e_push  = we & ~e_full;
            wcnt    = wcnt + int'(e_push);
            e_level = wcnt - s2;
            e_full  = (e_level == 8);
            e_af    = (e_level >= 6);
            s2      = s1;
            s1      = rcnt;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        if ({waddr_o, wr_gray_ptr_o, full_o, almost_full_o, wr_level_o, overflow_o} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_outputs got waddr=%0d gray=%h full=%b af=%b lvl=%0d ovf=%b want all 0",
                     waddr_o, wr_gray_ptr_o, full_o, almost_full_o, wr_level_o, overflow_o);
        end
        n_cmp++;
        if (obs_push !== 1'b1) begin
            n_bad++; $display("FAIL reset_push got %b want 1", obs_push);
        end
        n_cmp++;
    endtask

    task automatic test_fill();
        logic [3:0] gtab [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        tick(1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0);
            if (waddr_o !== 3'(k % 8) || wr_gray_ptr_o !== gtab[k-1]) begin
                n_bad++;
                $display("FAIL fill_ptr write %0d got addr=%0d gray=%h want addr=%0d gray=%h",
                         k, waddr_o, wr_gray_ptr_o, k % 8, gtab[k-1]);
            end
            n_cmp++;
            if (full_o !== (k == 8) || almost_full_o !== (k >= 6) || wr_level_o !== 4'(k)) begin
                n_bad++;
                $display("FAIL fill_flags write %0d got full=%b af=%b lvl=%0d want full=%b af=%b lvl=%0d",
                         k, full_o, almost_full_o, wr_level_o, k == 8, k >= 6, k);
            end
            n_cmp++;
        end
    endtask

    task automatic test_overflow();
        tick(1'b1, 1'b0);
        if (overflow_o !== 1'b1 || obs_push !== 1'b0 || waddr_o !== 3'd0 || wr_gray_ptr_o !== 4'hC) begin
            n_bad++;
            $display("FAIL overflow_hit got ovf=%b push=%b addr=%0d gray=%h want 1 0 0 c",
                     overflow_o, obs_push, waddr_o, wr_gray_ptr_o);
        end
        n_cmp++;
        tick(1'b0, 1'b0);
        if (overflow_o !== 1'b0 || full_o !== 1'b1) begin
            n_bad++; $display("FAIL overflow_pulse got ovf=%b full=%b want 0 1", overflow_o, full_o);
        end
        n_cmp++;
    endtask

    task automatic test_read_release();
        rcnt = 2;
        for (int c = 1; c <= 3; c++) begin
            tick(1'b0, 1'b0);
            if (full_o !== (c < 3)) begin
                n_bad++; $display("FAIL release_full cycle %0d got %b want %b", c, full_o, c < 3);
            end
            n_cmp++;
        end
        if (wr_level_o !== 4'd6 || almost_full_o !== 1'b1) begin
            n_bad++; $display("FAIL release_level got lvl=%0d af=%b want 6 1", wr_level_o, almost_full_o);
        end
        n_cmp++;
    endtask

    task automatic test_wrap();
        logic seen_wrap = 1'b0;
        tick(1'b0, 1'b1);
        for (int c = 0; c < 34; c++) begin
            if (c < 24 && rcnt < wcnt) rcnt++;
            tick(1'b1, 1'b0);
            if (wcnt == 16 && e_push) begin
                seen_wrap = 1'b1;
                if (wr_gray_ptr_o !== 4'h0) begin
                    n_bad++; $display("FAIL wrap_gray got %h want 0", wr_gray_ptr_o);
                end
                n_cmp++;
            end
            if ({waddr_o, wr_gray_ptr_o, full_o, wr_level_o} !== {3'(wcnt % 8), gray_of(wcnt), e_full, 4'(e_level)}) begin
                n_bad++;
                $display("FAIL wrap_state cycle %0d got addr=%0d gray=%h full=%b lvl=%0d want %0d %h %b %0d",
                         c, waddr_o, wr_gray_ptr_o, full_o, wr_level_o, wcnt % 8, gray_of(wcnt), e_full, e_level);
            end
            n_cmp++;
        end
        if (seen_wrap !== 1'b1 || full_o !== 1'b1) begin
            n_bad++; $display("FAIL wrap_reached got wrap=%b full=%b want 1 1", seen_wrap, full_o);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
        if (wr_level_o !== 4'd5) begin
            n_bad++; $display("FAIL mid_level got %0d want 5", wr_level_o);
        end
        n_cmp++;
        tick(1'b1, 1'b1);
        if ({waddr_o, wr_gray_ptr_o, full_o, almost_full_o, wr_level_o, overflow_o} !== 14'h0) begin
            n_bad++;
            $display("FAIL mid_reset got addr=%0d gray=%h full=%b af=%b lvl=%0d ovf=%b want all 0",
                     waddr_o, wr_gray_ptr_o, full_o, almost_full_o, wr_level_o, overflow_o);
        end
        n_cmp++;
        tick(1'b1, 1'b0);
        if (obs_push !== 1'b1 || waddr_o !== 3'd1 || wr_level_o !== 4'd1) begin
            n_bad++;
            $display("FAIL mid_first_write got push=%b addr=%0d lvl=%0d want 1 1 1", obs_push, waddr_o, wr_level_o);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        logic [3:0] prev_gray;
        tick(1'b0, 1'b1);
        prev_gray = wr_gray_ptr_o;
        for (int c = 0; c < 800; c++) begin
            if (rcnt < wcnt && $urandom_range(0, 99) < 45) rcnt++;
            tick(($urandom_range(0, 99) < 70), 1'b0);
            if (obs_push !== e_push || (pre_full && obs_push)) begin
                n_bad++; $display("FAIL rand_push cycle %0d got %b want %b full=%b", c, obs_push, e_push, pre_full);
            end
            n_cmp++;
            if (popcount4(wr_gray_ptr_o ^ prev_gray) > 1) begin
                n_bad++; $display("FAIL rand_hamming cycle %0d got %h after %h want <=1 bit change", c, wr_gray_ptr_o, prev_gray);
            end
            n_cmp++;
            prev_gray = wr_gray_ptr_o;
            if ({waddr_o, wr_gray_ptr_o, full_o, almost_full_o, wr_level_o, overflow_o} !==
                {3'(wcnt % 8), gray_of(wcnt), e_full, e_af, 4'(e_level), e_ovf}) begin
                n_bad++;
                $display("FAIL rand_state cycle %0d got addr=%0d gray=%h full=%b af=%b lvl=%0d ovf=%b want %0d %h %b %b %0d %b",
                         c, waddr_o, wr_gray_ptr_o, full_o, almost_full_o, wr_level_o, overflow_o,
                         wcnt % 8, gray_of(wcnt), e_full, e_af, e_level, e_ovf);
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
